pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline register for the pipelined CPU, used between stages (D/E, E/M, M/W).
- Carries an instruction word, PC and a generic payload bus through NUM_STAGES chained slots.
- Adds a valid/ready handshake, a per-slot 2-entry skid buffer and a flush that inserts bubbles.
- Bubbles present a programmable NOP instruction word downstream.

---
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register for the CPU stage boundaries (D/E, E/M, M/W).
// NUM_STAGES chained slots, each a main register plus a one-entry skid register.
// Ports: clk, reset (async, active-high), flush (sync bubble insert),
//        in_valid/in_ready/in_instr/in_pc/in_data (upstream beat),
//        out_valid/out_ready/out_instr/out_pc/out_data (downstream beat, gated to NOP/0 when invalid),
//        occupancy (valid entries held across all slots).
// Optional: define PIPE_STAGE_REG_STATS_EN to add saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_reg #(
    parameter int          DATA_W     = 64,
    parameter int          PC_W       = 32,
    parameter int          NUM_STAGES = 1,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [31:0]                         in_instr,
    input  logic [PC_W-1:0]                     in_pc,
    input  logic [DATA_W-1:0]                   in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [31:0]                         out_instr,
    output logic [PC_W-1:0]                     out_pc,
    output logic [DATA_W-1:0]                   out_data,
    output logic [$clog2(2*NUM_STAGES+1)-1:0]   occupancy
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    output logic [31:0]                         stall_cnt,
    output logic [31:0]                         bubble_cnt
`endif
);
    localparam int N  = NUM_STAGES;
    localparam int OW = $clog2(2*NUM_STAGES+1);

    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
        $error("pipe_stage_reg: NUM_STAGES must be in 1..8");
    end

    logic [N-1:0]        mv, sv, iv, dr, fi;
    logic [31:0]         m_instr [N];
    logic [31:0]         s_instr [N];
    logic [31:0]         ii      [N];
    logic [PC_W-1:0]     m_pc    [N];
    logic [PC_W-1:0]     s_pc    [N];
    logic [PC_W-1:0]     ip      [N];
    logic [DATA_W-1:0]   m_data  [N];
    logic [DATA_W-1:0]   s_data  [N];
    logic [DATA_W-1:0]   id      [N];
    logic                in_fire, out_fire;

    // Slot g takes its beat from slot g-1 (or the upstream port) and sees the
    // registered ready of slot g+1 (or out_ready for the last slot).
    for (genvar g = 0; g < N; g++) begin : g_chain
        if (g == 0) begin : g_first
            assign iv[g] = in_valid;
            assign ii[g] = in_instr;
            assign ip[g] = in_pc;
            assign id[g] = in_data;
        end else begin : g_rest
            assign iv[g] = mv[g-1];
            assign ii[g] = m_instr[g-1];
            assign ip[g] = m_pc[g-1];
            assign id[g] = m_data[g-1];
        end
        if (g == N-1) begin : g_last
            assign dr[g] = out_ready;
        end else begin : g_mid
            assign dr[g] = ~sv[g+1];
        end
    end

    // A slot's ready is just its empty skid, so a full skid blocks intake even
    // on the edge it drains into main.
    assign fi        = iv & ~sv;
    assign in_ready  = ~sv[0];
    assign out_valid = mv[N-1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_instr = out_valid ? m_instr[N-1] : NOP_INSTR;
    assign out_pc    = out_valid ? m_pc[N-1] : '0;
    assign out_data  = out_valid ? m_data[N-1] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mv        <= '0;
            sv        <= '0;
            occupancy <= '0;
            for (int k = 0; k < N; k++) begin
                m_instr[k] <= '0;
                m_pc[k]    <= '0;
                m_data[k]  <= '0;
                s_instr[k] <= '0;
                s_pc[k]    <= '0;
                s_data[k]  <= '0;
            end
        end else if (flush) begin
            mv        <= '0;
            sv        <= '0;
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OW'(in_fire) - OW'(out_fire);
            for (int k = 0; k < N; k++) begin
                if (!mv[k] || dr[k]) begin
                    mv[k]      <= sv[k] | fi[k];
                    sv[k]      <= 1'b0;
                    m_instr[k] <= sv[k] ? s_instr[k] : ii[k];
                    m_pc[k]    <= sv[k] ? s_pc[k] : ip[k];
                    m_data[k]  <= sv[k] ? s_data[k] : id[k];
                end else if (fi[k]) begin
                    sv[k]      <= 1'b1;
                    s_instr[k] <= ii[k];
                    s_pc[k]    <= ip[k];
                    s_data[k]  <= id[k];
                end
            end
        end
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    // Survive flush; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && out_ready && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg, one NUM_STAGES=1 and one NUM_STAGES=3 instance sharing stimulus.
module tb_pipe_stage_reg;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [63:0] in_data = '0;

    logic        rdy1, ov1, rdy3, ov3;
    logic [31:0] oi1, op1, oi3, op3;
    logic [63:0] od1, od3;
    logic [1:0]  occ1;
    logic [2:0]  occ3;
`ifdef PIPE_STAGE_REG_STATS_EN
    logic [31:0] st1, bb1, st3, bb3;
`endif

    int    n_tests = 0;
    int    n_fail = 0;
    beat_t q1[$];
    beat_t q3[$];
    beat_t e1, e3;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .PC_W(32), .NUM_STAGES(1), .NOP_INSTR(NOP)) u1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_instr(oi1), .out_pc(op1), .out_data(od1),
        .occupancy(occ1)
`ifdef PIPE_STAGE_REG_STATS_EN
        , .stall_cnt(st1), .bubble_cnt(bb1)
`endif
    );

    pipe_stage_reg #(.DATA_W(64), .PC_W(32), .NUM_STAGES(3), .NOP_INSTR(NOP)) u3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy3), .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready), .out_instr(oi3), .out_pc(op3), .out_data(od3),
        .occupancy(occ3)
`ifdef PIPE_STAGE_REG_STATS_EN
        , .stall_cnt(st3), .bubble_cnt(bb3)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
        in_valid = v;
        in_instr = i;
        in_pc    = p;
        in_data  = {~i, p};
    endtask

    // Scoreboard: push on in_fire, pop on out_fire, flush/reset discard.
    always @(negedge clk) begin
        if (reset) begin
            q1.delete();
            q3.delete();
        end else begin
            if (!ov1) chk("u1 gate", {oi1, op1, od1}, {NOP, 32'h0, 64'h0});
            if (!ov3) chk("u3 gate", {oi3, op3, od3}, {NOP, 32'h0, 64'h0});
            if (ov1 && out_ready) begin
                n_tests++;
                assert (q1.size() != 0) else begin
                    n_fail++;
                    $error("FAIL u1 sb: observed unexpected beat %h expected none", oi1);
                end
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    chk("u1 order", {oi1, op1, od1}, e1);
                end
            end
            if (ov3 && out_ready) begin
                n_tests++;
                assert (q3.size() != 0) else begin
                    n_fail++;
                    $error("FAIL u3 sb: observed unexpected beat %h expected none", oi3);
                end
                if (q3.size() != 0) begin
                    e3 = q3.pop_front();
                    chk("u3 order", {oi3, op3, od3}, e3);
                end
            end
            if (flush) begin
                q1.delete();
                q3.delete();
            end else begin
                if (in_valid && rdy1) q1.push_back({in_instr, in_pc, in_data});
                if (in_valid && rdy3) q3.push_back({in_instr, in_pc, in_data});
            end
        end
    end

    initial begin
        int          idx;
        logic        acc;
        logic [31:0] exp_pc;
        // reset asserted between edges
        #2 reset = 1'b1;
        #1;
        chk("rst ov1", ov1, 0);
        chk("rst instr1", oi1, NOP);
        chk("rst rdy1", rdy1, 1);
        chk("rst occ1", occ1, 0);
        chk("rst ov3", ov3, 0);
        chk("rst rdy3", rdy3, 1);
        tick;
        tick;
        reset = 1'b0;
        // streaming
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h2001_0001 + i, 32'h1000 + 4*i);
            tick;
            chk("stream occ1", occ1, 1);
            chk("stream out1", oi1, 32'h2001_0001 + i);
            if (i >= 2) chk("stream out3", oi3, 32'h2001_0001 + i - 2);
            else chk("stream lat3", ov3, 0);
        end
        chk("stream occ3", occ3, 3);
        drive(1'b0, 0, 0);
        repeat (3) tick;
        chk("stream end occ1", occ1, 0);
        chk("stream end occ3", occ3, 0);
        // backpressure
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'hA0 + idx, 32'h2000 + 4*idx);
            acc = rdy3;
            tick;
            if (acc) idx++;
        end
        chk("bp accepted3", idx, 6);
        chk("bp rdy3", rdy3, 0);
        chk("bp occ3", occ3, 6);
        chk("bp occ1", occ1, 2);
        chk("bp rdy1", rdy1, 0);
        chk("bp head3", oi3, 32'hA0);
        out_ready = 1'b1;
        for (int c = 0; c < 60 && (idx < 8 || q1.size() != 0 || q3.size() != 0); c++) begin
            drive(idx < 8, 32'hA0 + idx, 32'h2000 + 4*idx);
            acc = rdy3 && in_valid;
            tick;
            if (acc) idx++;
        end
        drive(1'b0, 0, 0);
        chk("bp total3", idx, 8);
        chk("bp drained3", occ3, 0);
        chk("bp drained1", occ1, 0);
        chk("bp sb3 empty", q3.size(), 0);
        // flush colliding with in_fire
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hB0 + i, 32'h4000 + 4*i);
            tick;
        end
        chk("fl occ3", occ3, 3);
        chk("fl occ1", occ1, 2);
        drive(1'b1, 32'hDEAD_0001, 32'h5000);
        flush = 1'b1;
        chk("fl rdy3 pre", rdy3, 1);
        tick;
        flush = 1'b0;
        drive(1'b0, 0, 0);
        chk("fl occ3 post", occ3, 0);
        chk("fl ov3 post", ov3, 0);
        chk("fl rdy3 post", rdy3, 1);
        chk("fl instr3 post", oi3, NOP);
        chk("fl occ1 post", occ1, 0);
        chk("fl rdy1 post", rdy1, 1);
        out_ready = 1'b1;
        repeat (4) tick;
        chk("fl no dead3", occ3, 0);
        // skid path with toggling out_ready
        exp_pc = 32'h3000;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            drive(1'b1, 32'hC0 + idx, 32'h3000 + 4*idx);
            if (ov1 && out_ready) begin
                chk("skid pc1", op1, exp_pc);
                exp_pc += 4;
            end
            acc = rdy1;
            tick;
            if (acc) idx++;
            chk("skid rdy1", rdy1, out_ready);
        end
        drive(1'b0, 0, 0);
        out_ready = 1'b1;
        repeat (10) tick;
        chk("skid drained1", occ1, 0);
        chk("skid drained3", occ3, 0);
        chk("skid sb1 empty", q1.size(), 0);
        // asynchronous reset mid-stall
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hE0 + i, 32'h6000 + 4*i);
            tick;
        end
        chk("ar occ3 pre", occ3, 4);
        chk("ar rdy1 pre", rdy1, 0);
        #2 reset = 1'b1;
        #1;
        chk("ar occ3", occ3, 0);
        chk("ar data3", od3, 0);
        chk("ar rdy3", rdy3, 1);
        chk("ar ov3", ov3, 0);
        chk("ar instr3", oi3, NOP);
        chk("ar occ1", occ1, 0);
        chk("ar rdy1", rdy1, 1);
        chk("ar data1", od1, 0);
        drive(1'b0, 0, 0);
        tick;
        reset = 1'b0;
        // statistics: 3 bubble edges, then stalls
        out_ready = 1'b1;
        repeat (3) tick;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'hF0 + i, 32'h7000 + 4*i);
            tick;
        end
        chk("st occ1", occ1, 2);
        chk("st occ3", occ3, 6);
`ifdef PIPE_STAGE_REG_STATS_EN
        chk("st stall1", st1, 5);
        chk("st bubble1", bb1, 3);
        chk("st stall3", st3, 1);
        chk("st bubble3", bb3, 3);
`endif
        drive(1'b0, 0, 0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("st flush occ1", occ1, 0);
        chk("st flush occ3", occ3, 0);
`ifdef PIPE_STAGE_REG_STATS_EN
        chk("st flush stall1", st1, 5);
        chk("st flush bubble1", bb1, 3);
        chk("st flush stall3", st3, 1);
        chk("st flush bubble3", bb3, 3);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
